dsp_sample_fifo: RTL and testbench

DSP_SAMPLE_FIFO -- requirements
Module: dsp_sample_fifo

---
 rtl/dsp_sample_fifo.sv | 101 ++++++++++
 tb/tb_dsp_sample_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_sample_fifo.sv
// Channel-tagged sample FIFO with first-word fall-through: a push into an empty FIFO is visible at the head after that edge.
// Backpressure: pktInReady_o = !full and never depends on pop; writes that are rejected or carry a bad channel are counted.
module dsp_sample_fifo #(
   parameter int PKT_WIDTH = 16,
   parameter int DEPTH     = 8,
   parameter int NUM_CH    = 2,
   parameter int CHG_MODE  = 1,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic                 clkDSP_i,
   input  logic                 rstDSP_n_i,
   input  logic [PKT_WIDTH-1:0] pktIn_i,
   input  logic [CH_W-1:0]      chIn_i,
   input  logic                 pktInValid_i,
   output logic                 pktInReady_o,
   output logic [PKT_WIDTH-1:0] pktDSP_o,
   output logic [CH_W-1:0]      chDSP_o,
   output logic                 pktValidDSP_o,
   input  logic                 pktReadyDSP_i,
   output logic                 pktChangedDSP_o,
   input  logic                 flush_i,
   input  logic                 clrOvf_i,
   output logic [LVL_W-1:0]     level_o,
   output logic                 ovfSticky_o,
   output logic [7:0]           dropCnt_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PKT_WIDTH-1:0] memPkt [DEPTH];
   logic [CH_W-1:0]      memCh  [DEPTH];
   logic [PKT_WIDTH-1:0] lastPkt [NUM_CH];

   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [LVL_W-1:0] level;
   logic             ovf;
   logic [7:0]       dropCnt;
   logic             full, empty, chOk, doPush, doPop, rejFull, dropInc;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign chOk    = (32'(chIn_i) < NUM_CH);
   assign doPush  = pktInValid_i && !full && chOk && !flush_i;
   assign doPop   = !empty && pktReadyDSP_i && !flush_i;
   assign rejFull = pktInValid_i && full;
   // a bad-channel write that also hits a full FIFO is counted once
   assign dropInc = pktInValid_i && (full || !chOk);

   always_ff @(posedge clkDSP_i or negedge rstDSP_n_i) begin
      if (!rstDSP_n_i) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         level   <= '0;
         ovf     <= 1'b0;
         dropCnt <= '0;
         for (int c = 0; c < NUM_CH; c++) lastPkt[c] <= '0;
      end else begin
         if (flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
         end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop) begin
               rdPtr            <= rdPtr + PTR_W'(1);
               lastPkt[chDSP_o] <= pktDSP_o;
            end
            unique case ({doPush, doPop})
               2'b10:   level <= level + LVL_W'(1);
               2'b01:   level <= level - LVL_W'(1);
               default: level <= level;
            endcase
         end

         // a rejected write in the same cycle as a clear wins
         if (rejFull)       ovf <= 1'b1;
         else if (clrOvf_i) ovf <= 1'b0;

         if (clrOvf_i)                        dropCnt <= {7'd0, dropInc};
         else if (dropInc && dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
      end
   end

   always_ff @(posedge clkDSP_i) begin
      if (doPush) begin
         memPkt[wrPtr] <= pktIn_i;
         memCh[wrPtr]  <= chIn_i;
      end
   end

   assign pktDSP_o        = memPkt[rdPtr];
   assign chDSP_o         = memCh[rdPtr];
   assign pktValidDSP_o   = !empty;
   assign pktInReady_o    = !full;
   assign level_o         = level;
   assign ovfSticky_o     = ovf;
   assign dropCnt_o       = dropCnt;
   assign pktChangedDSP_o = pktValidDSP_o && ((CHG_MODE == 0) || (pktDSP_o != lastPkt[chDSP_o]));

endmodule

// File: tb/tb_dsp_sample_fifo.sv
// Directed bench for dsp_sample_fifo (DEPTH=8, NUM_CH=2, CHG_MODE=1); outputs sampled 1ns after the rising edge.
module tb_dsp_sample_fifo;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] pktIn;
   logic [0:0]  chIn;
   logic        inValid;
   logic        inReady;
   logic [15:0] pktOut;
   logic [0:0]  chOut;
   logic        outValid;
   logic        outReady;
   logic        changed;
   logic        flush;
   logic        clrOvf;
   logic [3:0]  level;
   logic        ovf;
   logic [7:0]  dropCnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dsp_sample_fifo #(
      .PKT_WIDTH(16), .DEPTH(8), .NUM_CH(2), .CHG_MODE(1)
   ) dut (
      .clkDSP_i       (clk),
      .rstDSP_n_i     (rstN),
      .pktIn_i        (pktIn),
      .chIn_i         (chIn),
      .pktInValid_i   (inValid),
      .pktInReady_o   (inReady),
      .pktDSP_o       (pktOut),
      .chDSP_o        (chOut),
      .pktValidDSP_o  (outValid),
      .pktReadyDSP_i  (outReady),
      .pktChangedDSP_o(changed),
      .flush_i        (flush),
      .clrOvf_i       (clrOvf),
      .level_o        (level),
      .ovfSticky_o    (ovf),
      .dropCnt_o      (dropCnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushOne(input logic [0:0] ch, input logic [15:0] val);
      chIn = ch; pktIn = val; inValid = 1'b1;
      tick();
      inValid = 1'b0;
   endtask

   task automatic popOne();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
   endtask

   initial begin
      rstN = 1'b0; pktIn = '0; chIn = '0; inValid = 1'b0;
      outReady = 1'b0; flush = 1'b0; clrOvf = 1'b0;
      #1;
      check("rst_valid",   32'(outValid), 32'd0);
      check("rst_ready",   32'(inReady),  32'd1);
      check("rst_level",   32'(level),    32'd0);
      check("rst_ovf",     32'(ovf),      32'd0);
      check("rst_drop",    32'(dropCnt),  32'd0);
      check("rst_changed", 32'(changed),  32'd0);
      tick();
      rstN = 1'b1;

      // first push into an empty FIFO, consumer not ready
      pushOne(1'b0, 16'h1234);
      check("first_valid",   32'(outValid), 32'd1);
      check("first_pkt",     32'(pktOut),   32'h1234);
      check("first_ch",      32'(chOut),    32'd0);
      check("first_changed", 32'(changed),  32'd1);
      check("first_level",   32'(level),    32'd1);
      tick();
      check("hold_pkt",   32'(pktOut), 32'h1234);
      check("hold_level", 32'(level),  32'd1);
      popOne();
      check("pop_level", 32'(level), 32'd0);

      // per-channel change detection
      pushOne(1'b1, 16'h00AA);
      check("chg_ch1_a", 32'(changed), 32'd1);
      popOne();
      pushOne(1'b0, 16'h00AA);
      check("chg_ch0", 32'(changed), 32'd1);
      popOne();
      pushOne(1'b1, 16'h00AA);
      check("chg_ch1_b", 32'(changed), 32'd0);
      popOne();

      // overfill: 10 pushes into 8 entries
      chIn = 1'b0; inValid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pktIn = 16'h0100 + 16'(i);
         tick();
      end
      inValid = 1'b0;
      check("full_level", 32'(level),   32'd8);
      check("full_ready", 32'(inReady), 32'd0);
      check("full_ovf",   32'(ovf),     32'd1);
      check("full_drop",  32'(dropCnt), 32'd2);
      check("full_head",  32'(pktOut),  32'h0100);

      // push+pop while full: pop happens, push rejected
      pktIn = 16'h01FF; inValid = 1'b1; outReady = 1'b1;
      tick();
      inValid = 1'b0; outReady = 1'b0;
      check("fullpp_level", 32'(level),   32'd7);
      check("fullpp_drop",  32'(dropCnt), 32'd3);
      for (int i = 1; i < 8; i++) begin
         check("drain_order", 32'(pktOut), 32'h0100 + 32'(i));
         popOne();
      end
      check("drain_level", 32'(level),    32'd0);
      check("drain_valid", 32'(outValid), 32'd0);

      // steady push+pop at level 4 across pointer wrap
      chIn = 1'b1; inValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pktIn = 16'h0200 + 16'(i);
         tick();
      end
      check("steady_fill", 32'(level), 32'd4);
      outReady = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pktIn = 16'h0204 + 16'(i);
         check("steady_head", 32'(pktOut), 32'h0200 + 32'(i));
         tick();
         check("steady_level", 32'(level), 32'd4);
      end
      inValid = 1'b0; outReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("steady_tail", 32'(pktOut), 32'h0214 + 32'(i));
         popOne();
      end

      // flush at level 5 with a push pending
      chIn = 1'b0; inValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pktIn = 16'h0300 + 16'(i);
         tick();
      end
      check("pre_flush_level", 32'(level), 32'd5);
      pktIn = 16'h0999; flush = 1'b1;
      tick();
      flush = 1'b0; inValid = 1'b0;
      check("flush_level", 32'(level),    32'd0);
      check("flush_valid", 32'(outValid), 32'd0);
      check("flush_ovf",   32'(ovf),      32'd1);
      check("flush_drop",  32'(dropCnt),  32'd3);
      pushOne(1'b1, 16'h0217);
      check("flush_last_changed", 32'(changed), 32'd0);
      check("flush_repush_level", 32'(level),   32'd1);
      popOne();

      // clear, then clear colliding with a rejected write
      clrOvf = 1'b1;
      tick();
      clrOvf = 1'b0;
      check("clr_ovf",  32'(ovf),     32'd0);
      check("clr_drop", 32'(dropCnt), 32'd0);
      chIn = 1'b0; inValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pktIn = 16'h0400 + 16'(i);
         tick();
      end
      pktIn = 16'h04FF; clrOvf = 1'b1;
      tick();
      clrOvf = 1'b0; inValid = 1'b0;
      check("clrrej_ovf",  32'(ovf),     32'd1);
      check("clrrej_drop", 32'(dropCnt), 32'd1);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      popOne();
      check("empty_pop_level", 32'(level),   32'd0);
      check("empty_pop_ready", 32'(inReady), 32'd1);

      // asynchronous reset between edges at level 3
      chIn = 1'b1; inValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pktIn = 16'h0500 + 16'(i);
         tick();
      end
      inValid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd3);
      #3 rstN = 1'b0;
      #1;
      check("arst_level",   32'(level),    32'd0);
      check("arst_valid",   32'(outValid), 32'd0);
      check("arst_ready",   32'(inReady),  32'd1);
      check("arst_ovf",     32'(ovf),      32'd0);
      check("arst_drop",    32'(dropCnt),  32'd0);
      check("arst_changed", 32'(changed),  32'd0);
      #1 rstN = 1'b1;
      pushOne(1'b1, 16'h0217);
      check("post_rst_valid",   32'(outValid), 32'd1);
      check("post_rst_pkt",     32'(pktOut),   32'h0217);
      check("post_rst_level",   32'(level),    32'd1);
      check("post_rst_changed", 32'(changed),  32'd1);

      // saturation of the drop counter over 300 rejected writes
      chIn = 1'b0; pktIn = 16'h0600; inValid = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("sat_fill_level", 32'(level),   32'd8);
      check("sat_fill_drop",  32'(dropCnt), 32'd0);
      for (int i = 0; i < 254; i++) tick();
      check("sat_drop_254", 32'(dropCnt), 32'd254);
      tick();
      check("sat_drop_255", 32'(dropCnt), 32'd255);
      for (int i = 0; i < 45; i++) tick();
      inValid = 1'b0;
      check("sat_drop_300", 32'(dropCnt), 32'd255);
      check("sat_ovf",      32'(ovf),     32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
